// File: rtl/button_debounce_pkg.sv
// Shared state encoding and width helper for the push-button debouncer.
package button_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED   = 2'd0,
        ST_PRESS_PEND = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_REL_PEND   = 2'd3
    } state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchroniser for an asynchronous pin; RST_VAL sets the reset level of both flops.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit level/press/release/long pulses.
// Long-press detection is built only when BUTTON_LONG_PRESS_EN is defined; otherwise long_o is tied 0.
module button_debounce
    import button_pkg::*;
#(
    parameter int CLK_FREQ        = 100_000_000,
    parameter int DEBOUNCE_CYCLES = CLK_FREQ / 100,
    parameter int LONG_CYCLES     = CLK_FREQ,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic btn_sync;
    logic lvl;

    // Both flops reset to the idle pin level so reset never looks like a press.
    sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (btn_i),
        .q_o   (btn_sync)
    );

    assign lvl = btn_sync ^ ACTIVE_LOW;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pressed_q, pressed_d;
    logic               press_q, press_d;
    logic               release_q, release_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RELEASED: begin
                if (lvl) begin
                    state_d = ST_PRESS_PEND;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_PEND: begin
                if (!lvl) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!lvl) begin
                    state_d = ST_REL_PEND;
                    cnt_d   = '0;
                end
            end
            ST_REL_PEND: begin
                if (lvl) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RELEASED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Pulses only on the accepting transitions; a bounce back to the old state is silent.
    always_comb begin
        press_d   = (state_q == ST_PRESS_PEND) && (state_d == ST_PRESSED);
        release_d = (state_q == ST_REL_PEND) && (state_d == ST_RELEASED);
        pressed_d = (state_d == ST_PRESSED) || (state_d == ST_REL_PEND);
    end

    assign pressed_o = pressed_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int               HOLD_W    = cnt_width(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;
    logic              hold_run;

    assign hold_run = (state_q == ST_PRESSED) || (state_q == ST_REL_PEND);

    // Saturation at HOLD_MAX is what limits long_o to one pulse per press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if (hold_run && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule
